io_in_router: RTL and testbench

- Input-side counterpart of the 16:1 project output mux in the user area.
- Receives framed words on the 16 io_in pads using a toggle handshake from an external host.
- Selects the active project. Drives that selection to the output mux select.
- Delivers payload words to the selected project on a shared data bus, with a one-hot per-project valid strobe.

---
 rtl/io_in_router_if.sv | 38 +++
 rtl/io_in_router.sv | 148 ++++++++++++++
 tb/tb_io_in_router.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/io_in_router_if.sv
// io_in_router_if: host pad word and project-side delivery bus of io_in_router.
// master = host/test side, slave = router.
// parity_err_cnt is present only when IO_ROUTER_PARITY_EN is defined.
interface io_in_router_if #(
  parameter int DWIDTH = 8,
  parameter int NPROJ  = 16,
  parameter int SELW   = 4
);
  logic [15:0]       io_in;
  logic [DWIDTH-1:0] proj_data;
  logic [NPROJ-1:0]  proj_valid;
  logic [SELW-1:0]   proj_sel;
  logic              ack_toggle;
  logic              frame_busy;
  logic              frame_err;
  logic [7:0]        words_left;
`ifdef IO_ROUTER_PARITY_EN
  logic [7:0]        parity_err_cnt;
`endif

  modport master (
    output io_in,
    input  proj_data, proj_valid, proj_sel, ack_toggle,
           frame_busy, frame_err, words_left
`ifdef IO_ROUTER_PARITY_EN
    , input parity_err_cnt
`endif
  );

  modport slave (
    input  io_in,
    output proj_data, proj_valid, proj_sel, ack_toggle,
           frame_busy, frame_err, words_left
`ifdef IO_ROUTER_PARITY_EN
    , output parity_err_cnt
`endif
  );
endinterface

// File: rtl/io_in_router.sv
// io_in_router: receives toggle-handshaked framed words on the 16 io_in pads,
// selects the active project (feeds the output mux select) and delivers
// payload words to it with a one-hot single-cycle valid strobe.
// Optional build macro: IO_ROUTER_PARITY_EN (io_in[13] becomes an even-parity
// bit over {io_in[14], io_in[12:0]}; adds the parity_err_cnt output).
module io_in_router #(
  parameter int DWIDTH = 8,
  parameter int NPROJ  = 16,
  parameter int SELW   = 4
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  io_in_router_if.slave bus
);
  typedef enum logic {ST_IDLE = 1'b0, ST_PAYLOAD = 1'b1} state_t;

  state_t            state_reg, state_next;
  logic [15:0]       sync1_reg, sync2_reg;
  logic              last_stb_reg;
  logic [1:0]        prime_reg;
  logic              armed_reg;
  logic              ack_reg, ack_next;
  logic [SELW-1:0]   sel_reg, sel_next;
  logic [DWIDTH-1:0] data_reg, data_next;
  logic [NPROJ-1:0]  valid_reg, valid_next;
  logic              err_reg, err_next;
  logic [7:0]        left_reg, left_next;

  logic              detect;
  logic              is_hdr;
  logic [13:0]       body;
  logic [4:0]        hdr_id;
  logic [7:0]        hdr_len;
  logic              parity_ok;
  logic              unused_body;

  assign detect  = armed_reg && (sync2_reg[15] != last_stb_reg);
  assign is_hdr  = sync2_reg[14];
  assign body    = sync2_reg[13:0];
  assign hdr_id  = {1'b0, body[11:8]};
  assign hdr_len = body[7:0];
  assign unused_body = ^body[13:12];

`ifdef IO_ROUTER_PARITY_EN
  logic [7:0] perr_reg, perr_next;
  // Even parity: XOR over bits 14..0 (including the parity bit) must be 0.
  assign parity_ok = ~^sync2_reg[14:0];
  assign bus.parity_err_cnt = perr_reg;
`else
  assign parity_ok = 1'b1;
`endif

  // Pad synchronizer and arming. Arming waits until sync2 holds real pad
  // data, so an STB already high at reset release is not seen as a toggle.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      sync1_reg    <= '0;
      sync2_reg    <= '0;
      last_stb_reg <= 1'b0;
      prime_reg    <= '0;
      armed_reg    <= 1'b0;
    end else begin
      sync1_reg    <= bus.io_in;
      sync2_reg    <= sync1_reg;
      last_stb_reg <= sync2_reg[15];
      if (prime_reg != 2'd2) prime_reg <= prime_reg + 2'd1;
      armed_reg    <= (prime_reg == 2'd2);
    end
  end

  // Frame state and output registers.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_reg <= ST_IDLE;
      ack_reg   <= 1'b0;
      sel_reg   <= '0;
      data_reg  <= '0;
      valid_reg <= '0;
      err_reg   <= 1'b0;
      left_reg  <= '0;
`ifdef IO_ROUTER_PARITY_EN
      perr_reg  <= '0;
`endif
    end else begin
      state_reg <= state_next;
      ack_reg   <= ack_next;
      sel_reg   <= sel_next;
      data_reg  <= data_next;
      valid_reg <= valid_next;
      err_reg   <= err_next;
      left_reg  <= left_next;
`ifdef IO_ROUTER_PARITY_EN
      perr_reg  <= perr_next;
`endif
    end
  end

  // Word decode: every detected word is acknowledged, then acted on by type.
  always_comb begin
    state_next = state_reg;
    ack_next   = ack_reg;
    sel_next   = sel_reg;
    data_next  = data_reg;
    valid_next = '0;
    err_next   = err_reg;
    left_next  = left_reg;
`ifdef IO_ROUTER_PARITY_EN
    perr_next  = perr_reg;
`endif
    if (detect) begin
      ack_next = ~ack_reg;
      if (!parity_ok) begin
        err_next = 1'b1;
`ifdef IO_ROUTER_PARITY_EN
        if (perr_reg != 8'hFF) perr_next = perr_reg + 8'd1;
`endif
      end else if (is_hdr) begin
        if (hdr_id >= 5'(NPROJ)) begin
          // Bad project id: drop any open frame, keep current selection.
          err_next   = 1'b1;
          state_next = ST_IDLE;
          left_next  = '0;
        end else begin
          // A header arriving mid-frame aborts it and leaves the error set.
          err_next   = (state_reg == ST_PAYLOAD);
          sel_next   = hdr_id[SELW-1:0];
          left_next  = hdr_len;
          state_next = (hdr_len != 8'd0) ? ST_PAYLOAD : ST_IDLE;
        end
      end else if (state_reg == ST_IDLE) begin
        err_next = 1'b1;
      end else begin
        data_next  = body[DWIDTH-1:0];
        valid_next = NPROJ'(1) << sel_reg;
        left_next  = left_reg - 8'd1;
        if (left_reg == 8'd1) state_next = ST_IDLE;
      end
    end
  end

  assign bus.proj_data  = data_reg;
  assign bus.proj_valid = valid_reg;
  assign bus.proj_sel   = sel_reg;
  assign bus.ack_toggle = ack_reg;
  assign bus.frame_busy = (state_reg == ST_PAYLOAD);
  assign bus.frame_err  = err_reg;
  assign bus.words_left = left_reg;
endmodule

// File: tb/tb_io_in_router.sv
// tb_io_in_router: directed + random host words against a frame-level
// reference model. Built with NPROJ=8 so header ids 8..15 are out of range.
module tb_io_in_router;
  localparam int DW = 8;
  localparam int NP = 8;
  localparam int SW = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  io_in_router_if #(.DWIDTH(DW), .NPROJ(NP), .SELW(SW)) bus();
  io_in_router #(.DWIDTH(DW), .NPROJ(NP), .SELW(SW)) dut (
    .wb_clk_i(clk),
    .wb_rst_i(rst),
    .bus     (bus)
  );

  int checks = 0;
  int failures = 0;

  // Reference model state (frame-level view)
  bit              m_busy;
  int              m_sel;
  int              m_left;
  bit              m_err;
  bit              m_ack;
  logic [DW-1:0]   m_data;
  int              m_perr;
  logic [NP+DW-1:0] exp_q[$];
  logic [NP+DW-1:0] got_q[$];
  bit              stb;

  // Record every cycle that shows a strobe; a stretched pulse shows up twice.
  always @(negedge clk) begin
    if (bus.proj_valid !== '0) got_q.push_back({bus.proj_valid, bus.proj_data});
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_sel = 0; m_left = 0; m_err = 0; m_ack = 0; m_data = '0; m_perr = 0;
    exp_q.delete();
  endtask

  task automatic model_word(input bit h, input logic [13:0] b, input bit par_ok);
    int id;
    int len;
    logic [NP-1:0] oh;
    m_ack = ~m_ack;
    if (!par_ok) begin
      m_err = 1;
      if (m_perr < 255) m_perr++;
      return;
    end
    if (h) begin
      id  = int'(b[11:8]);
      len = int'(b[7:0]);
      if (id >= NP) begin
        m_err = 1; m_busy = 0; m_left = 0;
      end else begin
        m_err  = m_busy;
        m_sel  = id;
        m_left = len;
        m_busy = (len > 0);
      end
    end else if (!m_busy) begin
      m_err = 1;
    end else begin
      m_data = b[DW-1:0];
      oh = '0;
      oh[m_sel] = 1'b1;
      exp_q.push_back({oh, m_data});
      m_left--;
      if (m_left == 0) m_busy = 0;
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, ":proj_sel"},   32'(bus.proj_sel),   32'(m_sel));
    check({tag, ":frame_busy"}, 32'(bus.frame_busy), 32'(m_busy));
    check({tag, ":frame_err"},  32'(bus.frame_err),  32'(m_err));
    check({tag, ":words_left"}, 32'(bus.words_left), 32'(m_left));
    check({tag, ":proj_data"},  32'(bus.proj_data),  32'(m_data));
    check({tag, ":ack_toggle"}, 32'(bus.ack_toggle), 32'(m_ack));
`ifdef IO_ROUTER_PARITY_EN
    check({tag, ":parity_err_cnt"}, 32'(bus.parity_err_cnt), 32'(m_perr));
`endif
    check({tag, ":pulse_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    while (got_q.size() > 0 && exp_q.size() > 0)
      check({tag, ":pulse"}, 32'(got_q.pop_front()), 32'(exp_q.pop_front()));
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic send(input bit h, input logic [13:0] b, input bit bad_par);
    logic [13:0] w;
    bit ok;
    bit seen;
    w  = b;
    ok = 1'b1;
`ifdef IO_ROUTER_PARITY_EN
    w[13] = (^{h, b[12:0]}) ^ bad_par;
    ok    = !bad_par;
`endif
    @(negedge clk);
    bus.io_in[14:0] = {h, w};
    repeat (3) @(negedge clk);
    stb = ~stb;
    bus.io_in[15] = stb;
    model_word(h, w, ok);
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (bus.ack_toggle === m_ack) begin
        seen = 1;
        break;
      end
    end
    check("ack_within_budget", 32'(seen), 32'd1);
    repeat (2) @(negedge clk);
    $display("word hdr=%0d body=%04h bad_par=%0d -> sel=%0d busy=%0d err=%0d left=%0d",
             h, w, bad_par, bus.proj_sel, bus.frame_busy, bus.frame_err, bus.words_left);
    compare_all(h ? "hdr" : "data");
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst:proj_valid", 32'(bus.proj_valid), 32'd0);
    check("rst:proj_data",  32'(bus.proj_data),  32'd0);
    check("rst:proj_sel",   32'(bus.proj_sel),   32'd0);
    check("rst:ack_toggle", 32'(bus.ack_toggle), 32'd0);
    check("rst:frame_busy", 32'(bus.frame_busy), 32'd0);
    check("rst:frame_err",  32'(bus.frame_err),  32'd0);
    check("rst:words_left", 32'(bus.words_left), 32'd0);
    repeat (3) @(negedge clk);
    got_q.delete();
    model_reset();
    rst = 1'b0;
    repeat (10) @(negedge clk);
    $display("reset released stb=%0d", stb);
    check("post_rst:no_pulse", 32'(got_q.size()), 32'd0);
    check("post_rst:ack_toggle", 32'(bus.ack_toggle), 32'd0);
    check("post_rst:proj_sel", 32'(bus.proj_sel), 32'd0);
  endtask

  function automatic logic [13:0] hdr_body(input int id, input int len);
    return {2'b00, 4'(id), 8'(len)};
  endfunction

  initial begin
    bit bp;
    stb = 1'b1;
    bus.io_in = 16'h8000;
    model_reset();

    // Reset with STB already high: no spurious word afterwards.
    do_reset();

    // Frame to project 2, three payload words.
    send(1, hdr_body(2, 3), 0);
    send(0, 14'h00A5, 0);
    send(0, 14'h003C, 0);
    send(0, 14'h00FF, 0);

    // Select-only header.
    send(1, hdr_body(1, 0), 0);

    // Abort by a new header, then a clean header clears the error.
    send(1, hdr_body(0, 4), 0);
    send(0, 14'h0012, 0);
    send(0, 14'h0034, 0);
    send(1, hdr_body(5, 1), 0);
    send(0, 14'h0011, 0);
    send(1, hdr_body(0, 0), 0);

    // Data while idle, then clean header; out-of-range id.
    send(0, 14'h0077, 0);
    send(1, hdr_body(3, 0), 0);
    send(1, hdr_body(15, 2), 0);
    send(1, hdr_body(7, 1), 0);
    send(0, 14'h2A5A, 0);

`ifdef IO_ROUTER_PARITY_EN
    send(1, hdr_body(4, 2), 0);
    send(0, 14'h0055, 1);
    send(0, 14'h0066, 0);
`endif

    // Randomized words.
    for (int i = 0; i < 80; i++) begin
      bp = 0;
`ifdef IO_ROUTER_PARITY_EN
      bp = ($urandom_range(0, 9) == 0);
`endif
      if ($urandom_range(0, 99) < 35)
        send(1, hdr_body(int'($urandom_range(0, 15)), int'($urandom_range(0, 3))), bp);
      else
        send(0, 14'($urandom), bp);
    end

    // Reset mid-frame discards the frame.
    send(1, hdr_body(6, 3), 0);
    send(0, 14'h0042, 0);
    do_reset();
    send(0, 14'h0043, 0);
    send(1, hdr_body(6, 1), 0);
    send(0, 14'h0044, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
